// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Round-robin pick. Scans (last+1) .. (last+4) mod N_REQ and returns
    // {found, idx} for the first requester that is asserted and not masked.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] last,
        input logic [N_REQ-1:0] mask
    );
        logic [N_REQ-1:0] cand;
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        cand = req & ~mask;
        res  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            // 2-bit addition wraps naturally, giving the mod-4 scan order.
            idx = last + IDX_W'(k);
            if (!res[IDX_W] && cand[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/decod_2x4.sv
// 2-to-4 line decoder: A is the MSB, B the LSB; exactly one Y output is high.
module decod_2x4 (
    input  logic A,
    input  logic B,
    output logic Y0,
    output logic Y1,
    output logic Y2,
    output logic Y3
);

    // Plain AND-plane decode of the two select bits.
    always_comb begin
        Y0 = ~A & ~B;
        Y1 = ~A &  B;
        Y2 =  A & ~B;
        Y3 =  A &  B;
    end

endmodule

// File: rtl/arb_rr_4.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// The owner is held as a 2-bit index; the one-hot grant is that index
// decoded and gated by gnt_valid. All state and outputs are registered,
// so a request sampled at one edge shows up as a grant right after it.
module arb_rr_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    // The hold counter must be able to represent MAX_HOLD-1.
    if (MAX_HOLD < 0 || (2 ** CNT_W) <= MAX_HOLD) begin : g_cnt_w_check
        $error("arb_rr_4: CNT_W too small for MAX_HOLD (need 2**CNT_W > MAX_HOLD)");
    end

    // Last count value before a timeout; with preemption disabled the
    // counter simply saturates at all-ones.
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = (MAX_HOLD == 0) ? '1 : HOLD_LAST;

    state_e           state_q,   state_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic             valid_q,   valid_d;
    logic             preempt_q, preempt_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [IDX_W-1:0] last_q,    last_d;

    logic [IDX_W:0]   pick_all;
    logic [IDX_W:0]   pick_oth;
    logic [N_REQ-1:0] own_mask;
    logic             owner_req;
    logic             timeout;
    logic [N_REQ-1:0] dec_y;

    // Candidate winners: one over all requesters (fresh grant from IDLE),
    // one with the current owner masked out (handoff and preemption).
    always_comb begin
        own_mask  = N_REQ'(1) << idx_q;
        owner_req = req[idx_q];
        pick_all  = rr_pick(req, last_q, '0);
        pick_oth  = rr_pick(req, last_q, own_mask);
        timeout   = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
    end

    // Next-state logic: grant, hold, handoff, preemption and the hold counter.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                cnt_d   = '0;
                if (en && pick_all[IDX_W]) begin
                    state_d = ST_GRANT;
                    idx_d   = pick_all[IDX_W-1:0];
                    last_d  = pick_all[IDX_W-1:0];
                    valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    // A drop wins over a coincident timeout: no preempt pulse.
                    if (en && pick_oth[IDX_W]) begin
                        idx_d  = pick_oth[IDX_W-1:0];
                        last_d = pick_oth[IDX_W-1:0];
                        cnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (timeout && en && pick_oth[IDX_W]) begin
                    idx_d     = pick_oth[IDX_W-1:0];
                    last_d    = pick_oth[IDX_W-1:0];
                    cnt_d     = '0;
                    preempt_d = 1'b1;
                end else if (cnt_q != HOLD_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset leaves requester 0 with top priority (last = 3).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            cnt_q     <= '0;
            last_q    <= '1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    decod_2x4 u_dec (
        .A  (idx_q[1]),
        .B  (idx_q[0]),
        .Y0 (dec_y[0]),
        .Y1 (dec_y[1]),
        .Y2 (dec_y[2]),
        .Y3 (dec_y[3])
    );

    // Outputs come straight from registers; gnt is forced to zero when idle.
    always_comb begin
        gnt       = dec_y & {N_REQ{valid_q}};
        gnt_idx   = idx_q;
        gnt_valid = valid_q;
        preempt   = preempt_q;
    end

endmodule
